// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// SWITCH_DEBOUNCE_SIM_FAST_EN (consumed by switch_debounce) selects DEB_FAST_THRESH.
package switch_debounce_pkg;

    typedef enum logic {
        DEB_STABLE = 1'b0,
        DEB_SETTLE = 1'b1
    } deb_state_t;

    localparam int DEB_WIDTH_DEF         = 24;
    localparam int DEB_STABLE_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz
    localparam int DEB_FAST_THRESH       = 4;        // short threshold for CPU-level sims

endpackage

// File: rtl/switch_debounce_sync_chain.sv
// Multi-bit flop chain bringing the asynchronous switch pins into the clock domain.
// Bits are synchronised independently; the debouncer downstream hides any
// cross-bit skew because the vector must then hold still before it commits.
module sync_chain #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    // Shift the raw vector one stage down the chain each cycle.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Chain registers; reset only for deterministic simulation start-up.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the board DIP switches as one vector.
// `switches` only takes a value after the synchronised input has held it for
// the full threshold; `changed` pulses in that commit cycle.
// Define SWITCH_DEBOUNCE_SIM_FAST_EN to use a 4-cycle threshold for simulation.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH         = DEB_WIDTH_DEF,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] switches,
    output logic             changed,
    output logic             settling
);

`ifdef SWITCH_DEBOUNCE_SIM_FAST_EN
    localparam int THRESH = DEB_FAST_THRESH;
`else
    localparam int THRESH = STABLE_CYCLES;
`endif
    localparam int             CNT_W    = $clog2(THRESH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

    logic [WIDTH-1:0] s_sync;

    deb_state_t       state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic             chg_q, chg_d;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (sw_raw),
        .q     (s_sync)
    );

    // Next-state: track a candidate vector and time how long it holds.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        count_d = count_q;
        sw_d    = sw_q;
        chg_d   = 1'b0;
        case (state_q)
            DEB_STABLE: begin
                if (s_sync != sw_q) begin
                    cand_d  = s_sync;
                    count_d = '0;
                    state_d = DEB_SETTLE;
                end
            end
            DEB_SETTLE: begin
                if (s_sync == sw_q) begin
                    // bounced back to the committed value: drop the candidate
                    count_d = '0;
                    state_d = DEB_STABLE;
                end else if (s_sync != cand_q) begin
                    // any further movement restarts the timer on the new vector
                    cand_d  = s_sync;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    sw_d    = cand_q;
                    chg_d   = 1'b1;
                    count_d = '0;
                    state_d = DEB_STABLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DEB_STABLE;
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DEB_STABLE;
            cand_q  <= '0;
            count_q <= '0;
            sw_q    <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            sw_q    <= sw_d;
            chg_q   <= chg_d;
        end
    end

    assign switches = sw_q;
    assign changed  = chg_q;
    assign settling = (state_q == DEB_SETTLE);

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: directed scenarios plus random
// stimulus, all compared every cycle against a history-based reference model.
// Adapts to SWITCH_DEBOUNCE_SIM_FAST_EN (threshold 4, STABLE_CYCLES 1000000).
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    localparam int W    = 24;
    localparam int SYNC = 2;
`ifdef SWITCH_DEBOUNCE_SIM_FAST_EN
    localparam int SC  = 1000000;
    localparam int THR = 4;
`else
    localparam int SC  = 8;
    localparam int THR = 8;
`endif
    localparam int LAT = SYNC + 1 + THR;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] switches;
    logic         changed;
    logic         settling;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    switch_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .switches (switches),
        .changed  (changed),
        .settling (settling)
    );

    // Reference model: the FSM sees sw_raw SYNC edges late; a value commits when
    // it has been seen on THR+1 consecutive edges while differing from switches.
    logic [W-1:0] m_pipe [SYNC];
    logic [W-1:0] m_hist [THR];
    logic [W-1:0] m_sw;
    logic         m_chg, m_set;

    always @(posedge clock) begin : model
        logic [W-1:0] obs;
        logic         hold;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] <= '0;
            for (int i = 0; i < THR; i++)  m_hist[i] <= '0;
            m_sw  <= '0;
            m_chg <= 1'b0;
            m_set <= 1'b0;
        end else begin
            obs  = m_pipe[SYNC-1];
            hold = (obs != m_sw);
            for (int i = 0; i < THR; i++) if (m_hist[i] != obs) hold = 1'b0;
            m_pipe[0] <= sw_raw;
            for (int i = 1; i < SYNC; i++) m_pipe[i] <= m_pipe[i-1];
            m_hist[0] <= obs;
            for (int i = 1; i < THR; i++) m_hist[i] <= m_hist[i-1];
            m_sw  <= hold ? obs : m_sw;
            m_chg <= hold;
            m_set <= hold ? 1'b0 : (obs != m_sw);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sw_raw = '0;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sw_raw = 24'h5A5A5A;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if ({switches, changed, settling} !== {24'h0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state: got sw=%h chg=%b set=%b, want all zero", switches, changed, settling);
            end
        end
        reset  = 1'b0;
        sw_raw = '0;
    endtask

    // Clean step: commit exactly LAT edges after the first sampling edge.
    task automatic test_step(input logic [W-1:0] val);
        do_reset();
        sw_raw = val;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            n_chk++;
            if ({switches, changed, settling} !== {m_sw, m_chg, m_set}) begin
                n_fail++;
                $display("FAIL step_model k=%0d: got sw=%h chg=%b set=%b, want sw=%h chg=%b set=%b", k, switches, changed, settling, m_sw, m_chg, m_set);
            end
            n_chk++;
            if (k < LAT && (switches !== '0 || changed !== 1'b0)) begin
                n_fail++;
                $display("FAIL step_early k=%0d: got sw=%h chg=%b, want 0/0", k, switches, changed);
            end else if (k == LAT && (switches !== val || changed !== 1'b1)) begin
                n_fail++;
                $display("FAIL step_commit k=%0d: got sw=%h chg=%b, want %h/1", k, switches, changed, val);
            end else if (k == LAT + 1 && (switches !== val || changed !== 1'b0)) begin
                n_fail++;
                $display("FAIL step_after k=%0d: got sw=%h chg=%b, want %h/0", k, switches, changed, val);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        do_reset();
        for (int seg = 0; seg < 10; seg++) begin
            sw_raw = (seg % 2 == 0) ? 24'h000001 : 24'h000000;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (changed === 1'b1) pulses++;
                n_chk++;
                if ({switches, changed, settling} !== {m_sw, m_chg, m_set}) begin
                    n_fail++;
                    $display("FAIL bounce_model seg=%0d: got sw=%h chg=%b set=%b, want sw=%h chg=%b set=%b", seg, switches, changed, settling, m_sw, m_chg, m_set);
                end
            end
        end
        n_chk++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_no_pulse: got %0d changed pulses, want 0", pulses);
        end
        sw_raw = 24'h000001;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            n_chk++;
            if ((k < LAT && changed !== 1'b0) || (k == LAT && (changed !== 1'b1 || switches !== 24'h000001))) begin
                n_fail++;
                $display("FAIL bounce_commit k=%0d: got sw=%h chg=%b, want commit of 000001 at k=%0d", k, switches, changed, LAT);
            end
        end
    endtask

    task automatic test_glitch_back();
        bit saw_set  = 1'b0;
        int pulses   = 0;
        do_reset();
        sw_raw = 24'h000010;
        for (int k = 0; k < LAT + 2; k++) tick();
        n_chk++;
        if (switches !== 24'h000010) begin
            n_fail++;
            $display("FAIL glitch_setup: got sw=%h, want 000010", switches);
        end
        for (int k = 0; k < 12; k++) begin
            sw_raw = (k < 4) ? 24'h000000 : 24'h000010;
            tick();
            if (settling === 1'b1) saw_set = 1'b1;
            if (changed === 1'b1) pulses++;
            n_chk++;
            if ({switches, changed, settling} !== {m_sw, m_chg, m_set}) begin
                n_fail++;
                $display("FAIL glitch_model k=%0d: got sw=%h chg=%b set=%b, want sw=%h chg=%b set=%b", k, switches, changed, settling, m_sw, m_chg, m_set);
            end
        end
        n_chk++;
        if (!saw_set || settling !== 1'b0 || switches !== 24'h000010 || pulses != 0) begin
            n_fail++;
            $display("FAIL glitch_result: got saw_set=%b set=%b sw=%h pulses=%0d, want 1/0/000010/0", saw_set, settling, switches, pulses);
        end
    endtask

    task automatic test_staggered();
        int gap    = (THR > 5) ? 5 : THR - 1;
        int pulses = 0;
        do_reset();
        sw_raw = 24'h000008;
        for (int k = 0; k < gap; k++) begin
            tick();
            if (changed === 1'b1) pulses++;
        end
        sw_raw = 24'h000088;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (changed === 1'b1) pulses++;
            n_chk++;
            if ({switches, changed, settling} !== {m_sw, m_chg, m_set}) begin
                n_fail++;
                $display("FAIL stagger_model k=%0d: got sw=%h chg=%b set=%b, want sw=%h chg=%b set=%b", k, switches, changed, settling, m_sw, m_chg, m_set);
            end
            if (k == LAT) begin
                n_chk++;
                if (switches !== 24'h000088 || changed !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stagger_commit: got sw=%h chg=%b, want 000088/1", switches, changed);
                end
            end
        end
        n_chk++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL stagger_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_settle();
        int cnt = (THR > 6) ? 5 : THR - 2;
        do_reset();
        sw_raw = 24'hFFFFFF;
        for (int k = 0; k < 3 + cnt; k++) tick();
        n_chk++;
        if (settling !== 1'b1 || switches !== '0) begin
            n_fail++;
            $display("FAIL midreset_pre: got set=%b sw=%h, want 1/000000", settling, switches);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if (switches !== '0 || settling !== 1'b0 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got sw=%h set=%b chg=%b, want 0/0/0", switches, settling, changed);
        end
        for (int k = 1; k <= LAT; k++) begin
            tick();
            n_chk++;
            if ((k < LAT && (changed !== 1'b0 || switches !== '0)) ||
                (k == LAT && (changed !== 1'b1 || switches !== 24'hFFFFFF))) begin
                n_fail++;
                $display("FAIL midreset_commit k=%0d: got sw=%h chg=%b, want commit of FFFFFF at k=%0d", k, switches, changed, LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pool [4];
        do_reset();
        for (int i = 0; i < 4; i++) pool[i] = W'($urandom);
        pool[0] = '0;
        for (int seg = 0; seg < 60; seg++) begin
            int len = $urandom_range(1, THR + 4);
            sw_raw = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, W - 1));
            for (int c = 0; c < len; c++) begin
                tick();
                n_chk++;
                if ({switches, changed, settling} !== {m_sw, m_chg, m_set}) begin
                    n_fail++;
                    $display("FAIL random_model seg=%0d: got sw=%h chg=%b set=%b, want sw=%h chg=%b set=%b", seg, switches, changed, settling, m_sw, m_chg, m_set);
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        test_reset();
`ifdef SWITCH_DEBOUNCE_SIM_FAST_EN
        test_step(24'h123456);
`else
        test_step(24'h00A5F0);
`endif
        test_bounce();
        test_glitch_back();
        test_staggered();
        test_reset_mid_settle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the CPU's switch input port.
- Takes the 24 raw, asynchronous board DIP switches, synchronises them into the clock domain and debounces them as one vector.
- Presents a glitch-free `switches` vector to the switch latch consumed on IO reads.
- Also emits a one-cycle `changed` pulse so software-visible logic or LEDs can react to a committed change.

Parameters:
- WIDTH, 24, number of switch bits conditioned.
- STABLE_CYCLES, 1000000, consecutive cycles the synchronised vector must hold before commit (10 ms at 100 MHz); legal range ≥ 2.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser; legal range ≥ 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
- sw_raw  input  WIDTH  raw switch pins, asynchronous, may bounce.
- switches  output  WIDTH  debounced, committed switch vector; feeds the switch latch.
- changed  output  1  single-cycle pulse, high in the cycle `switches` takes a new value.
- settling  output  1  high while a candidate change is being timed (FSM in SETTLE).

Behaviour:
- Reset (synchronous, active-high) clears all state:
  - all synchroniser stages = 0, candidate = 0, count = 0;
  - `switches` = 0, `changed` = 0, `settling` = 0, FSM = STABLE.
- Synchroniser: `sw_raw` passes through SYNC_STAGES flops; call the last stage `s_sync`. No other logic samples `sw_raw`.
- Counter: width `$clog2(STABLE_CYCLES)`; never wraps, because it is cleared before reaching STABLE_CYCLES.
- FSM state STABLE:
  - if `s_sync` != `switches`: candidate <= `s_sync`, count <= 0, go to SETTLE;
  - else hold.
- FSM state SETTLE (`settling` = 1):
  - if `s_sync` == `switches` (bounced back): count <= 0, go to STABLE, no commit, no pulse;
  - else if `s_sync` != candidate (new bounce or a further bit change): candidate <= `s_sync`, count <= 0, stay in SETTLE;
  - else if count == STABLE_CYCLES-1: `switches` <= candidate, `changed` <= 1 for exactly this cycle, count <= 0, go to STABLE;
  - else count <= count + 1.
- `changed` is registered; it is 0 in every cycle except the commit cycle. Back-to-back commits are impossible: there is at least one STABLE cycle between commits.
- Latency: a clean `sw_raw` step, held constant, appears on `switches` (with `changed` = 1) exactly SYNC_STAGES + 1 + STABLE_CYCLES rising edges after the step was first sampled.
- Multi-bit change: the whole vector is debounced as a unit; bits changing on different cycles restart the timer, so they commit together.
- Reset asserted mid-SETTLE: the pending candidate is discarded and the outputs return to 0 the cycle after reset is sampled. After reset deasserts, a non-zero `sw_raw` commits after the full latency.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_SIM_FAST_EN.
- Defined: effective threshold is 4 cycles regardless of STABLE_CYCLES; counter width is sized for 4. Used for simulation and CPU-level tests.
- Undefined: threshold = STABLE_CYCLES, as above.

Decomposition:
- Shared package: FSM state enum `deb_state_t {DEB_STABLE, DEB_SETTLE}`, default WIDTH (24), default STABLE_CYCLES, and the fast-sim threshold constant (4).
- One natural sub-module: `sync_chain`, a parameterised multi-bit synchroniser with WIDTH and SYNC_STAGES parameters and `clock` only (no reset needed, but reset to 0 for deterministic simulation).
- FSM and counter live in the top module.

Test Plan (bench uses STABLE_CYCLES=8, SYNC_STAGES=2, WIDTH=24, macro undefined unless stated):
- Reset, then `sw_raw`=24'h00A5F0 held -> `switches`=24'h00A5F0 and `changed`=1 exactly 11 edges after first sample; `changed`=0 the next cycle.
- Bounce: `sw_raw` toggles bit0 0/1 every 3 cycles for 30 cycles, then settles at 1 -> no `changed` during bouncing; commit to 24'h000001 11 edges after the last toggle.
- Glitch back: `switches`=24'h000010, `sw_raw` pulses 24'h000000 for 4 cycles -> `settling` goes high then low, `switches` stays 24'h000010, `changed` never asserts.
- Staggered bits: bit3 set, bit7 set 5 cycles later -> single commit to 24'h000088 with one `changed` pulse, timed from the bit7 change.
- Reset mid-SETTLE: assert `reset` at count=5 with candidate 24'hFFFFFF -> next cycle `switches`=0, `settling`=0; after release, commit to 24'hFFFFFF after the full 11 edges.
- With SWITCH_DEBOUNCE_SIM_FAST_EN and STABLE_CYCLES=1000000: step to 24'h123456 -> commit after 2+1+4=7 edges.
